// File: rtl/otter_ecc_checker.sv
// Hamming(38,32) read-path checker: recomputes check bits, corrects single-bit
// data errors, flags uncorrectable syndromes, counts errors and requests a
// writeback of every corrected word through a two-state scrub handshake.
module otter_ecc_checker #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 MEM_CLK,
  input  logic                 MEM_RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [31:0]          IN_ADDR,
  input  logic [31:0]          IN_DATA,
  input  logic [5:0]           IN_PAR,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          OUT_DATA,
  output logic                 OUT_CE,
  output logic                 OUT_UE,
  output logic [5:0]           OUT_SYND,
  input  logic                 SCRUB_EN,
  output logic                 SCRUB_REQ,
  output logic [31:0]          SCRUB_ADDR,
  output logic [31:0]          SCRUB_DATA,
  input  logic                 SCRUB_ACK,
  output logic [CNT_WIDTH-1:0] CE_COUNT,
  output logic [CNT_WIDTH-1:0] UE_COUNT,
  input  logic                 CNT_CLR
);

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;

  typedef enum logic {IDLE, REQ} scrub_state_t;

  // Check bits over the data word; data bits occupy the non-power-of-two code
  // positions 3..38 in ascending order.
  function automatic logic [PAR_W-1:0] calc_check(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] c;
    int               idx;
    c   = '0;
    idx = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < PAR_W; k++) begin
          if (p[k]) c[k] = c[k] ^ d[idx[4:0]];
        end
        idx++;
      end
    end
    return c;
  endfunction

  // Invert the data bit whose code position equals the syndrome; syndromes that
  // are zero, a check-bit position or beyond 38 leave the word untouched.
  function automatic logic [DATA_W-1:0] correct_data(input logic [DATA_W-1:0] d,
                                                     input logic [PAR_W-1:0]  s);
    logic [DATA_W-1:0] r;
    int                idx;
    r   = d;
    idx = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (p[5:0] == s) r[idx[4:0]] = ~r[idx[4:0]];
        idx++;
      end
    end
    return r;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                 in_en;
  logic                 vld_p1;
  logic [DATA_W-1:0]    data_p1;
  logic [DATA_W-1:0]    addr_p1;
  logic [PAR_W-1:0]     synd_p1;
  logic                 vld_p2;
  logic [DATA_W-1:0]    data_p2;
  logic [DATA_W-1:0]    addr_p2;
  logic [PAR_W-1:0]     synd_p2;
  logic                 ce_p2;
  logic                 ue_p2;
  logic                 xfer_in;
  logic                 xfer_out;
  logic                 adv_p2;
  logic                 ce_p1;
  logic                 ue_p1;
  scrub_state_t         state_q;
  scrub_state_t         state_d;
  logic                 scrub_load;
  logic [DATA_W-1:0]    scrub_addr_q;
  logic [DATA_W-1:0]    scrub_data_q;
  logic [CNT_WIDTH-1:0] ce_cnt_q;
  logic [CNT_WIDTH-1:0] ue_cnt_q;

  // A word in stage 2 carrying a correctable error waits while a scrub is pending.
  assign OUT_VALID = vld_p2 && !(ce_p2 && SCRUB_EN && (state_q == REQ));
  assign xfer_out  = OUT_VALID && OUT_READY;
  assign adv_p2    = !vld_p2 || xfer_out;
  assign IN_READY  = in_en && (!vld_p1 || adv_p2);
  assign xfer_in   = IN_VALID && IN_READY;

  assign ce_p1 = (synd_p1 != 6'd0) && (synd_p1 <= 6'd38);
  assign ue_p1 = (synd_p1 > 6'd38);

  // Input acceptance is held off until the first edge after reset releases.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) in_en <= 1'b0;
    else            in_en <= 1'b1;
  end

  // ---- stage 1: capture word, address and syndrome ----
  // Stage 1 occupancy.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N)    vld_p1 <= 1'b0;
    else if (IN_READY) vld_p1 <= IN_VALID;
  end

  // Stage 1 payload; never observed unless vld_p1 is set.
  always_ff @(posedge MEM_CLK) begin
    if (xfer_in) begin
      data_p1 <= IN_DATA;
      addr_p1 <= IN_ADDR;
      synd_p1 <= calc_check(IN_DATA) ^ IN_PAR;
    end
  end

  // ---- stage 2: corrected word and classification ----
  // Stage 2 loads whenever its current word leaves or it is empty.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      addr_p2 <= '0;
      synd_p2 <= '0;
      ce_p2   <= 1'b0;
      ue_p2   <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= correct_data(data_p1, synd_p1);
        addr_p2 <= addr_p1;
        synd_p2 <= synd_p1;
        ce_p2   <= ce_p1;
        ue_p2   <= ue_p1;
      end
    end
  end

  assign OUT_DATA = data_p2;
  assign OUT_CE   = ce_p2;
  assign OUT_UE   = ue_p2;
  assign OUT_SYND = synd_p2;

  // ---- scrub handshake ----
  // Scrub state register.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state: a corrected word leaving while idle starts a scrub; ACK ends it.
  always_comb begin
    state_d    = state_q;
    scrub_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_out && ce_p2 && SCRUB_EN) begin
          scrub_load = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (SCRUB_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writeback address/data captured once per scrub and frozen while it is pending.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      scrub_addr_q <= '0;
      scrub_data_q <= '0;
    end else if (scrub_load) begin
      scrub_addr_q <= addr_p2;
      scrub_data_q <= data_p2;
    end
  end

  assign SCRUB_REQ  = (state_q == REQ);
  assign SCRUB_ADDR = scrub_addr_q;
  assign SCRUB_DATA = scrub_data_q;

  // ---- error statistics ----
  // Count only words that actually leave; clear beats a same-cycle increment.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else if (CNT_CLR) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else if (xfer_out) begin
      if (ce_p2) ce_cnt_q <= sat_inc(ce_cnt_q);
      if (ue_p2) ue_cnt_q <= sat_inc(ue_cnt_q);
    end
  end

  assign CE_COUNT = ce_cnt_q;
  assign UE_COUNT = ue_cnt_q;

endmodule

// File: tb/tb_otter_ecc_checker.sv
// Scoreboard bench for otter_ecc_checker: the driver queues hand-computed
// responses as words are accepted, a negedge monitor pops and compares them.
module tb_otter_ecc_checker;

  localparam int CW = 4;

  typedef struct {
    logic [31:0] data;
    logic        ce;
    logic        ue;
    logic [5:0]  synd;
  } exp_t;

  logic          MEM_CLK = 1'b0;
  logic          MEM_RST_N;
  logic          IN_VALID;
  logic          IN_READY;
  logic [31:0]   IN_ADDR;
  logic [31:0]   IN_DATA;
  logic [5:0]    IN_PAR;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [31:0]   OUT_DATA;
  logic          OUT_CE;
  logic          OUT_UE;
  logic [5:0]    OUT_SYND;
  logic          SCRUB_EN;
  logic          SCRUB_REQ;
  logic [31:0]   SCRUB_ADDR;
  logic [31:0]   SCRUB_DATA;
  logic          SCRUB_ACK;
  logic [CW-1:0] CE_COUNT;
  logic [CW-1:0] UE_COUNT;
  logic          CNT_CLR;

  logic rdy_drv;
  logic tog_q;
  logic tog_en;
  assign OUT_READY = tog_en ? tog_q : rdy_drv;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [5:0]  hold_synd;
  logic        hold_ce;
  logic        hold_ue;

  otter_ecc_checker #(.CNT_WIDTH(CW)) dut (
    .MEM_CLK   (MEM_CLK),
    .MEM_RST_N (MEM_RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_ADDR   (IN_ADDR),
    .IN_DATA   (IN_DATA),
    .IN_PAR    (IN_PAR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CE    (OUT_CE),
    .OUT_UE    (OUT_UE),
    .OUT_SYND  (OUT_SYND),
    .SCRUB_EN  (SCRUB_EN),
    .SCRUB_REQ (SCRUB_REQ),
    .SCRUB_ADDR(SCRUB_ADDR),
    .SCRUB_DATA(SCRUB_DATA),
    .SCRUB_ACK (SCRUB_ACK),
    .CE_COUNT  (CE_COUNT),
    .UE_COUNT  (UE_COUNT),
    .CNT_CLR   (CNT_CLR)
  );

  always #5 MEM_CLK = ~MEM_CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // OUT_READY toggler used for the backpressure sequence.
  initial begin
    tog_q = 1'b1;
    forever begin
      @(posedge MEM_CLK);
      #1;
      if (tog_en) tog_q = ~tog_q;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: outputs must hold while stalled; each transfer is matched in order.
  always @(negedge MEM_CLK) begin
    if (hold_pend && OUT_VALID) begin
      chk("hold_data", OUT_DATA, hold_data);
      chk("hold_synd", OUT_SYND, hold_synd);
      chk("hold_flags", {OUT_CE, OUT_UE}, {hold_ce, hold_ue});
    end
    hold_pend = OUT_VALID && !OUT_READY;
    hold_data = OUT_DATA;
    hold_synd = OUT_SYND;
    hold_ce   = OUT_CE;
    hold_ue   = OUT_UE;
    if (OUT_VALID && OUT_READY) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: got data 0x%0h synd %0d, expected no word", OUT_DATA, OUT_SYND);
      end else begin
        mon_e = q.pop_front();
        chk("out_data", OUT_DATA, mon_e.data);
        chk("out_ce", OUT_CE, mon_e.ce);
        chk("out_ue", OUT_UE, mon_e.ue);
        chk("out_synd", OUT_SYND, mon_e.synd);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [5:0] p, input logic [31:0] a,
                      input logic [31:0] ed, input logic ece, input logic eue,
                      input logic [5:0] es);
    exp_t e;
    bit   done;
    done     = 1'b0;
    IN_DATA  = d;
    IN_PAR   = p;
    IN_ADDR  = a;
    IN_VALID = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge MEM_CLK);
      if (IN_READY) begin
        e.data = ed;
        e.ce   = ece;
        e.ue   = eue;
        e.synd = es;
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge MEM_CLK);
      #1;
    end
    IN_VALID = 1'b0;
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: IN_READY stayed 0 for data 0x%0h, expected acceptance", d);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge MEM_CLK);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain: %0d words still pending, expected 0", q.size());
    end
    @(posedge MEM_CLK);
    #1;
  endtask

  task automatic wait_scrub();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge MEM_CLK);
      if (SCRUB_REQ) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL scrub_req_timeout: SCRUB_REQ=0, expected 1");
    end
  endtask

  task automatic ack_pulse();
    @(posedge MEM_CLK);
    #1;
    SCRUB_ACK = 1'b1;
    @(posedge MEM_CLK);
    #1;
    SCRUB_ACK = 1'b0;
  endtask

  logic [5:0]  pos_tab [8];
  logic [31:0] one_hot;
  bit          seen;

  initial begin
    pos_tab   = '{6'd3, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11, 6'd12};
    MEM_RST_N = 1'b0;
    IN_VALID  = 1'b0;
    IN_ADDR   = '0;
    IN_DATA   = '0;
    IN_PAR    = '0;
    rdy_drv   = 1'b1;
    tog_en    = 1'b0;
    SCRUB_EN  = 1'b0;
    SCRUB_ACK = 1'b0;
    CNT_CLR   = 1'b0;

    // Reset state
    repeat (3) @(posedge MEM_CLK);
    @(negedge MEM_CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_out_synd", OUT_SYND, 0);
    chk("rst_scrub_req", SCRUB_REQ, 0);
    chk("rst_scrub_addr", SCRUB_ADDR, 0);
    chk("rst_counts", {CE_COUNT, UE_COUNT}, 0);
    @(posedge MEM_CLK);
    #1;
    MEM_RST_N = 1'b1;
    @(negedge MEM_CLK);
    chk("in_ready_before_edge", IN_READY, 0);
    @(posedge MEM_CLK);
    #1;
    chk("in_ready_after_reset", IN_READY, 1);

    // Clean zero word and two-cycle latency
    send(32'h0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge MEM_CLK);
    chk("latency_stage1", OUT_VALID, 0);
    @(negedge MEM_CLK);
    chk("latency_stage2", OUT_VALID, 1);
    drain();

    // Single data-bit errors at d0 and d31
    send(32'h1, 6'h00, 32'h4, 32'h0, 1'b1, 1'b0, 6'd3);
    drain();
    chk("ce_count_1", CE_COUNT, 1);
    send(32'h8000_0000, 6'h00, 32'h8, 32'h0, 1'b1, 1'b0, 6'd38);

    // Check-bit error and uncorrectable syndrome
    send(32'h0, 6'h04, 32'hC, 32'h0, 1'b1, 1'b0, 6'd4);
    send(32'h0, 6'h3F, 32'h10, 32'h0, 1'b0, 1'b1, 6'd63);
    drain();
    chk("ce_count_3", CE_COUNT, 3);
    chk("ue_count_1", UE_COUNT, 1);

    // Clean non-zero words and a d31 flip of an all-ones word
    send(32'h0000_000F, 6'h07, 32'h14, 32'h0000_000F, 1'b0, 1'b0, 6'd0);
    send(32'hFFFF_FFFF, 6'h18, 32'h18, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd0);
    send(32'h7FFF_FFFF, 6'h18, 32'h1C, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'd38);
    drain();
    chk("ce_count_4", CE_COUNT, 4);

    // Eight back-to-back words with OUT_READY toggling
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      one_hot = 32'h1 << i;
      send(one_hot, 6'h00, 32'h40 + 32'(i), 32'h0, 1'b1, 1'b0, pos_tab[i]);
    end
    drain();
    tog_en = 1'b0;
    chk("ce_count_12", CE_COUNT, 12);
    chk("ue_count_still_1", UE_COUNT, 1);

    // Scrub: second corrected word withheld until the first scrub is acknowledged
    SCRUB_EN = 1'b1;
    send(32'h1, 6'h00, 32'h100, 32'h0, 1'b1, 1'b0, 6'd3);
    send(32'h2, 6'h00, 32'h104, 32'h0, 1'b1, 1'b0, 6'd5);
    wait_scrub();
    chk("scrub_addr_1", SCRUB_ADDR, 32'h100);
    chk("scrub_data_1", SCRUB_DATA, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge MEM_CLK);
      chk("scrub_req_held", SCRUB_REQ, 1);
      chk("second_withheld", OUT_VALID, 0);
      chk("scrub_addr_held", SCRUB_ADDR, 32'h100);
    end
    ack_pulse();
    @(negedge MEM_CLK);
    chk("scrub_idle_after_ack", SCRUB_REQ, 0);
    chk("second_released", OUT_VALID, 1);
    wait_scrub();
    chk("scrub_addr_2", SCRUB_ADDR, 32'h104);
    chk("scrub_data_2", SCRUB_DATA, 32'h0);
    ack_pulse();
    SCRUB_EN = 1'b0;
    drain();
    chk("scrub_done", SCRUB_REQ, 0);
    chk("ce_count_14", CE_COUNT, 14);

    // Saturation at all-ones
    send(32'h1, 6'h00, 32'h0, 32'h0, 1'b1, 1'b0, 6'd3);
    drain();
    chk("ce_count_15", CE_COUNT, 15);
    send(32'h1, 6'h00, 32'h0, 32'h0, 1'b1, 1'b0, 6'd3);
    drain();
    chk("ce_count_saturated", CE_COUNT, 15);

    // Clear in the same cycle as a CE transfer
    rdy_drv = 1'b0;
    send(32'h1, 6'h00, 32'h0, 32'h0, 1'b1, 1'b0, 6'd3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge MEM_CLK);
      seen = OUT_VALID;
    end
    chk("stalled_word_present", seen, 1);
    chk("stall_no_count", CE_COUNT, 15);
    @(posedge MEM_CLK);
    #1;
    CNT_CLR = 1'b1;
    rdy_drv = 1'b1;
    @(posedge MEM_CLK);
    #1;
    CNT_CLR = 1'b0;
    chk("clr_priority_ce", CE_COUNT, 0);
    chk("clr_priority_ue", UE_COUNT, 0);
    drain();

    // Reset while a scrub is pending and a word is in flight
    SCRUB_EN = 1'b1;
    send(32'h1, 6'h00, 32'h200, 32'h0, 1'b1, 1'b0, 6'd3);
    send(32'h2, 6'h00, 32'h204, 32'h0, 1'b1, 1'b0, 6'd5);
    wait_scrub();
    chk("scrub_addr_3", SCRUB_ADDR, 32'h200);
    @(posedge MEM_CLK);
    #2;
    MEM_RST_N = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_scrub_req", SCRUB_REQ, 0);
    chk("rst_mid_out_valid", OUT_VALID, 0);
    chk("rst_mid_in_ready", IN_READY, 0);
    chk("rst_mid_scrub_addr", SCRUB_ADDR, 0);
    chk("rst_mid_ce_count", CE_COUNT, 0);
    @(posedge MEM_CLK);
    #1;
    MEM_RST_N = 1'b1;
    SCRUB_EN  = 1'b0;
    @(posedge MEM_CLK);
    #1;
    chk("in_ready_after_rst2", IN_READY, 1);
    send(32'h0000_000F, 6'h07, 32'h300, 32'h0000_000F, 1'b0, 1'b0, 6'd0);
    drain();
    chk("post_rst_ce_count", CE_COUNT, 0);
    chk("post_rst_scrub_req", SCRUB_REQ, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
